prog_truth_table: RTL and testbench
===================================

# prog_truth_table

Programmable N-input Boolean function unit. It replaces fixed, hand-written gate-level and operator-level functions with a run-time-loadable truth table. A host shifts in 2^N_IN table bits serially; afterwards every valid input vector is evaluated with a registered, one-cycle result. It sits where a fixed combinational function block would, with valid qualifiers on both sides.

## Interface

- N_IN, 4, number of function inputs (2..6); table depth is 2^N_IN bits

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears all state
- load_start  input  1  begin (re)programming; one-cycle pulse
- load_valid  input  1  load_bit is valid this cycle
- load_bit  input  1  next truth-table bit, index 0 first
- in_vec  input  N_IN  function inputs; in_vec[N_IN-1] is A (MSB of table index)
- in_valid  input  1  in_vec valid this cycle
- Y  output  1  registered function result
- y_valid  output  1  one-cycle pulse, Y updated
- loaded  output  1  table complete and usable
- load_err  output  1  parity failure on last load (only with PROG_TT_PARITY_EN, else tied 0)

## Operation

- Storage: 2^N_IN-bit table register; index counter of N_IN+1 bits.
- States:
  - IDLE: reset state, unprogrammed.
  - LOAD: accepting table bits.
  - PAR: accepting parity bit (macro only).
  - RUN: evaluating.
- Transitions:
  - IDLE --load_start--> LOAD.
  - LOAD, on the load_valid that writes index 2^N_IN-1 --> RUN, or --> PAR with the macro.
  - PAR --load_valid--> RUN if parity matches, else IDLE with load_err=1.
  - RUN --load_start--> LOAD.
  - load_start in LOAD or PAR restarts at index 0.
- On entering LOAD: index=0, loaded=0, load_err=0. Table contents are not cleared; they are overwritten bit by bit.
- In LOAD, each load_valid writes table[index]=load_bit and increments index.
- load_start has priority over load_valid in the same cycle; that bit is discarded.
- Evaluation (RUN only): when in_valid=1, the next cycle gives Y=table[in_vec] and y_valid=1.
- in_valid is ignored in IDLE, LOAD and PAR: no y_valid, Y holds.
- in_valid in the same cycle as load_start in RUN is discarded; load_start wins.
- Y holds its last value when y_valid=0.
- Reset values: state=IDLE, table=0, index=0, Y=0, y_valid=0, loaded=0, load_err=0.

## Timing

- Evaluation latency is 1 cycle. Throughput is one vector per cycle, back-to-back.
- A load takes 2^N_IN accepted bits, plus 1 parity bit with the macro. Gaps in load_valid are allowed.
- loaded rises the cycle after the final accepted bit. With the macro, the final bit is the parity bit.
- An in_valid in that same following cycle is evaluated.
- Reset during LOAD or RUN takes effect at the next edge. A partial table is discarded and zeroed, and an in-flight y_valid is suppressed.
- Index does not wrap. Extra load_valid in RUN or IDLE is ignored.

## Configuration

- PROG_TT_PARITY_EN:
  - Defined: after the table, one extra load_valid carries the parity bit, which must equal XOR of all table bits.
  - On a match, the block enters RUN with loaded=1.
  - On a mismatch, it returns to IDLE with loaded=0 and load_err=1; load_err holds until the next load_start or reset.
- Undefined: there is no PAR state, load_err is tied to 0, and the load completes on the last table bit.

## Test plan

- Reset: hold reset 2 cycles -> Y=0, y_valid=0, loaded=0, load_err=0; in_valid pulses produce no y_valid.
- N_IN=3 load of Y=B|(A'C'): pulse load_start, then send bits 1,0,1,1,0,0,1,1 (table 0xCD), plus parity 1 with the macro -> loaded=1 one cycle after the last bit. Then stream in_vec 0..7 back-to-back -> Y sequence 1,0,1,1,0,0,1,1, each with y_valid, 1-cycle latency.
- Reprogram mid-run: in RUN, load_start, then load 0xFF -> loaded drops the cycle after load_start, no y_valid during LOAD; afterwards every in_vec gives Y=1.
- Restart and priority: in LOAD after 3 bits, assert load_start with load_valid=1 -> bit discarded, index=0; the full 8 bits are then still required before loaded=1.
- Reset mid-load: reset after 5 of 8 bits -> IDLE, table=0, loaded=0; in_valid gives no y_valid.
- Parity (macro only): load 0xCD with parity 0 -> IDLE, loaded=0, load_err=1; the next load_start clears load_err.

Source files
------------

// File: rtl/prog_truth_table.sv
// rtl/prog_truth_table.sv - run-time loadable N-input truth table with registered result
// Optional parity check on the loaded table: define PROG_TT_PARITY_EN.
module prog_truth_table #(
  parameter int N_IN = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_start,
  input  logic            load_valid,
  input  logic            load_bit,
  input  logic [N_IN-1:0] in_vec,
  input  logic            in_valid,
  output logic            Y,
  output logic            y_valid,
  output logic            loaded,
  output logic            load_err
);
  localparam int DEPTH = 1 << N_IN;
  localparam logic [N_IN:0] LAST_IDX = (N_IN + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PAR, RUN} state_t;

  state_t           state, stateNext;
  logic [DEPTH-1:0] ttable;
  logic [N_IN:0]    idx;
  logic             bitAccept, lastBit, evalFire, parOk, parFail;

  assign lastBit = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // load_start from any state restarts a load and outranks load_valid/in_valid
  always_comb begin
    stateNext = state;
    bitAccept = 1'b0;
    evalFire  = 1'b0;
    parOk     = 1'b0;
    parFail   = 1'b0;
    case (state)
      IDLE: if (load_start) stateNext = LOAD;
      LOAD: begin
        if (load_start) begin
          stateNext = LOAD;
        end else if (load_valid) begin
          bitAccept = 1'b1;
          if (lastBit) begin
`ifdef PROG_TT_PARITY_EN
            stateNext = PAR;
`else
            stateNext = RUN;
`endif
          end
        end
      end
`ifdef PROG_TT_PARITY_EN
      PAR: begin
        if (load_start) begin
          stateNext = LOAD;
        end else if (load_valid) begin
          if (load_bit == ^ttable) begin
            parOk     = 1'b1;
            stateNext = RUN;
          end else begin
            parFail   = 1'b1;
            stateNext = IDLE;
          end
        end
      end
`endif
      RUN: begin
        if (load_start)    stateNext = LOAD;
        else if (in_valid) evalFire  = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ttable  <= '0;
      idx     <= '0;
      Y       <= 1'b0;
      y_valid <= 1'b0;
      loaded  <= 1'b0;
    end else begin
      y_valid <= evalFire;
      if (evalFire) Y <= ttable[in_vec];
      if (load_start) begin
        idx    <= '0;
        loaded <= 1'b0;
      end else if (bitAccept) begin
        ttable[idx[N_IN-1:0]] <= load_bit;
        idx                   <= idx + 1'b1;
`ifndef PROG_TT_PARITY_EN
        if (lastBit) loaded <= 1'b1;
`endif
      end
      if (parOk) loaded <= 1'b1;
    end
  end

`ifdef PROG_TT_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset)           load_err <= 1'b0;
    else if (load_start) load_err <= 1'b0;
    else if (parFail)    load_err <= 1'b1;
  end
`else
  assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_truth_table.sv
// tb/tb_prog_truth_table.sv - self-checking bench for prog_truth_table (N_IN=3)
module tb_prog_truth_table;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_bit = 1'b0;
  logic [2:0] in_vec = '0;
  logic       in_valid = 1'b0;
  logic       Y, y_valid, loaded, load_err;

  int nCompared = 0;
  int nMismatched = 0;
  logic lastY = 1'b0;

  typedef struct {
    logic [2:0] vec;
    logic       expY;
  } vecRec_t;
  vecRec_t cdVecs[8];

  prog_truth_table #(.N_IN(3)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_bit(load_bit), .in_vec(in_vec), .in_valid(in_valid), .Y(Y),
    .y_valid(y_valid), .loaded(loaded), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One-cycle evaluation of a vector while in RUN
  task automatic evalVec(input logic [2:0] v, input logic expY);
    in_vec = v;
    in_valid = 1'b1;
    tick();
    check("evalValid", y_valid, 1'b1);
    check("evalY", Y, expY);
    lastY = expY;
    in_valid = 1'b0;
  endtask

  // Feed table bits idx 0 first (+ parity bit when enabled); no y_valid may appear
  task automatic sendBits(input logic [7:0] tbl, input logic parBit, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          load_valid = 1'b0;
          in_valid = 1'($urandom_range(0, 1));
          in_vec = 3'($urandom);
          tick();
          check("gapNoYvalid", y_valid, 1'b0);
          check("gapYhold", Y, lastY);
        end
      end
      load_valid = 1'b1;
      load_bit = tbl[i];
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      check("loadNoYvalid", y_valid, 1'b0);
      if (i < 7) check("loadedLow", loaded, 1'b0);
    end
`ifdef PROG_TT_PARITY_EN
    load_valid = 1'b1;
    load_bit = parBit;
    in_valid = 1'b0;
    tick();
    check("parNoYvalid", y_valid, 1'b0);
`else
    if (parBit === 1'bx) check("parBitX", 1'b0, 1'b1);
`endif
    load_valid = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic loadTable(input logic [7:0] tbl, input logic parBit, input bit gaps);
    load_start = 1'b1;
    in_valid = 1'b0;
    tick();
    load_start = 1'b0;
    check("loadedDropsOnStart", loaded, 1'b0);
    sendBits(tbl, parBit, gaps);
  endtask

  initial begin
    logic [7:0] tbl;
    logic       iv;
    logic [2:0] vv;

    cdVecs[0] = '{3'd0, 1'b1}; cdVecs[1] = '{3'd1, 1'b0};
    cdVecs[2] = '{3'd2, 1'b1}; cdVecs[3] = '{3'd3, 1'b1};
    cdVecs[4] = '{3'd4, 1'b0}; cdVecs[5] = '{3'd5, 1'b0};
    cdVecs[6] = '{3'd6, 1'b1}; cdVecs[7] = '{3'd7, 1'b1};

    // Reset: held 2 cycles with in_valid active
    in_valid = 1'b1;
    tick();
    tick();
    check("rstY", Y, 1'b0);
    check("rstYvalid", y_valid, 1'b0);
    check("rstLoaded", loaded, 1'b0);
    check("rstLoadErr", load_err, 1'b0);
    reset = 1'b0;
    tick();
    check("idleNoYvalid", y_valid, 1'b0);
    in_valid = 1'b0;

    // Load 0xCD (Y = B | A'C') then stream all vectors back-to-back
    loadTable(8'hCD, 1'b1, 1'b0);
    check("loadedCD", loaded, 1'b1);
    check("loadErrCD", load_err, 1'b0);
    for (int i = 0; i < 8; i++) begin
      in_vec = cdVecs[i].vec;
      in_valid = 1'b1;
      tick();
      check("cdValid", y_valid, 1'b1);
      check("cdY", Y, cdVecs[i].expY);
      lastY = cdVecs[i].expY;
    end
    in_valid = 1'b0;
    tick();
    check("cdValidDrop", y_valid, 1'b0);
    check("cdYhold", Y, lastY);

    // Reprogram mid-run: load_start beats a simultaneous in_valid
    load_start = 1'b1;
    in_valid = 1'b1;
    in_vec = 3'd1;
    tick();
    load_start = 1'b0;
    check("reprogLoadedDrop", loaded, 1'b0);
    check("reprogNoYvalid", y_valid, 1'b0);
    sendBits(8'hFF, 1'b0, 1'b1);
    check("loadedFF", loaded, 1'b1);
    for (int v = 0; v < 8; v++) evalVec(3'(v), 1'b1);

    // Restart with simultaneous load_valid: that bit is dropped, index back to 0
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_bit = 1'b1;
      tick();
    end
    load_start = 1'b1;
    load_valid = 1'b1;
    load_bit = 1'b1;
    tick();
    load_start = 1'b0;
    tbl = 8'h5A;
    for (int i = 0; i < 7; i++) begin
      load_valid = 1'b1;
      load_bit = tbl[i];
      tick();
    end
    check("restartNotLoaded7", loaded, 1'b0);
    load_bit = tbl[7];
    tick();
`ifdef PROG_TT_PARITY_EN
    check("restartNotLoadedPar", loaded, 1'b0);
    load_bit = ^tbl;
    tick();
`endif
    load_valid = 1'b0;
    check("restartLoaded", loaded, 1'b1);
    for (int v = 0; v < 8; v++) evalVec(3'(v), tbl[v]);

    // Reset after 5 of 8 bits
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_bit = 1'b1;
      tick();
    end
    load_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lastY = 1'b0;
    check("midRstLoaded", loaded, 1'b0);
    check("midRstY", Y, 1'b0);
    in_valid = 1'b1;
    tick();
    check("midRstNoYvalid", y_valid, 1'b0);
    in_valid = 1'b0;
    // Extra load_valid in IDLE must not complete anything
    load_valid = 1'b1;
    repeat (9) tick();
    load_valid = 1'b0;
    check("idleExtraBits", loaded, 1'b0);

`ifdef PROG_TT_PARITY_EN
    loadTable(8'hCD, 1'b0, 1'b0);
    check("parBadLoaded", loaded, 1'b0);
    check("parBadErr", load_err, 1'b1);
    in_valid = 1'b1;
    tick();
    check("parBadNoYvalid", y_valid, 1'b0);
    check("parErrHolds", load_err, 1'b1);
    in_valid = 1'b0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("parErrCleared", load_err, 1'b0);
`endif

    // Random tables with gaps, then random evaluation against the array model
    for (int r = 0; r < 4; r++) begin
      tbl = 8'($urandom);
      loadTable(tbl, ^tbl, 1'b1);
      check("rndLoaded", loaded, 1'b1);
      check("rndLoadErr", load_err, 1'b0);
      for (int c = 0; c < 40; c++) begin
        iv = 1'($urandom_range(0, 1));
        vv = 3'($urandom);
        in_valid = iv;
        in_vec = vv;
        tick();
        check("rndValid", y_valid, iv);
        if (iv) lastY = tbl[vv];
        check("rndY", Y, lastY);
      end
      in_valid = 1'b0;
      // Extra load_valid in RUN is ignored
      load_valid = 1'b1;
      load_bit = ~tbl[0];
      tick();
      load_valid = 1'b0;
      evalVec(3'd0, tbl[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
